// File: rtl/frac_div.sv
// Signed fractional divider, Q1.(n-1) operands and result.
// q = trunc((a * 2^(n-1)) / b), saturated to the Q1.(n-1) range, computed
// by restoring division on magnitudes followed by a sign/saturation stage.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; operands latched on the start edge
// RUN   | one restoring-division step per cycle, 2n-1 steps
// FIN   | apply sign and saturation, register result, pulse done
//
// done is driven by the edge that leaves FIN, so it is seen in the first
// IDLE cycle after the division. busy covers RUN and FIN, so a start held
// high while done is up begins the next division straight away.
module frac_div #(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    output logic [n-1:0] result,
    output logic         busy,
    output logic         done,
    output logic         div_zero
);

    localparam int NW = 2*n - 1;
    localparam int CW = $clog2(2*n);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

    localparam logic [NW-1:0] POS_LIMIT = NW'((1 << (n-1)) - 1);
    localparam logic [NW-1:0] NEG_LIMIT = NW'(1 << (n-1));
    localparam logic [n-1:0]  POS_MAX   = {1'b0, {(n-1){1'b1}}};
    localparam logic [n-1:0]  NEG_MAX   = {1'b1, {(n-1){1'b0}}};

    logic [1:0]    state;
    logic [CW-1:0] count;
    logic [NW-1:0] num;
    logic [n-1:0]  den;
    logic [n-1:0]  rem;
    logic [NW-1:0] quo;
    logic          a_neg;
    logic          b_neg;
    logic          a_zero;
    logic          b_zero;

    logic [n-1:0]  mag_a;
    logic [n-1:0]  mag_b;
    logic [n:0]    rem_sh;
    logic          rem_ge;
    logic [n-1:0]  rem_nxt;
    logic          q_neg;
    logic [n-1:0]  final_q;

    // Operand magnitudes; the most negative value maps to 2^(n-1) unsigned.
    always_comb begin
        mag_a = a[n-1] ? (~a + 1'b1) : a;
        mag_b = b[n-1] ? (~b + 1'b1) : b;
    end

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    // The remainder stays below den, so n-bit wraparound subtraction is exact.
    always_comb begin
        rem_sh  = {rem, num[NW-1]};
        rem_ge  = (rem_sh >= {1'b0, den});
        rem_nxt = rem_ge ? (rem_sh[n-1:0] - den) : rem_sh[n-1:0];
    end

    // Sign application, saturation and the divide-by-zero substitutes.
    always_comb begin
        q_neg   = (a_neg != b_neg) && !a_zero;
        final_q = '0;
        if (b_zero) begin
            if (a_zero)     final_q = '0;
            else if (a_neg) final_q = NEG_MAX;
            else            final_q = POS_MAX;
        end else if (q_neg) begin
            if (quo > NEG_LIMIT) final_q = NEG_MAX;
            else                 final_q = ~quo[n-1:0] + 1'b1;
        end else begin
            if (quo > POS_LIMIT) final_q = POS_MAX;
            else                 final_q = quo[n-1:0];
        end
    end

    // Controller, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            count    <= '0;
            num      <= '0;
            den      <= '0;
            rem      <= '0;
            quo      <= '0;
            a_neg    <= 1'b0;
            b_neg    <= 1'b0;
            a_zero   <= 1'b0;
            b_zero   <= 1'b0;
            result   <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        num    <= {mag_a, {(n-1){1'b0}}};
                        den    <= mag_b;
                        rem    <= '0;
                        quo    <= '0;
                        a_neg  <= a[n-1];
                        b_neg  <= b[n-1];
                        a_zero <= (a == '0);
                        b_zero <= (b == '0);
                        count  <= CW'(NW);
                        state  <= (b == '0) ? FIN : RUN;
                    end
                end
                RUN: begin
                    rem   <= rem_nxt;
                    quo   <= {quo[NW-2:0], rem_ge};
                    num   <= {num[NW-2:0], 1'b0};
                    count <= count - 1'b1;
                    if (count == CW'(1)) state <= FIN;
                end
                FIN: begin
                    result   <= final_q;
                    div_zero <= b_zero;
                    done     <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // busy is a pure decode of the state register.
    always_comb busy = (state != IDLE);

endmodule

// File: tb/tb_frac_div.sv
// Self-checking bench for frac_div (n = 8).
module tb_frac_div;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] result;
    logic       busy;
    logic       done;
    logic       div_zero;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int a;
        int b;
        int exp_q;
        int exp_dz;
    } vec_t;

    vec_t vecs[$];

    frac_div #(.n(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .result(result), .busy(busy), .done(done), .div_zero(div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the quotient definition.
    function automatic int ref_q(input int av, input int bv);
        int ma, mb, q;
        bit neg;
        if (bv == 0) return (av > 0) ? 127 : (av < 0) ? -128 : 0;
        ma  = (av < 0) ? -av : av;
        mb  = (bv < 0) ? -bv : bv;
        q   = (ma * 128) / mb;
        neg = ((av < 0) != (bv < 0)) && (av != 0);
        if (!neg) return (q > 127) ? 127 : q;
        return (q > 128) ? -128 : -q;
    endfunction

    function automatic int sres();
        return int'($signed(result));
    endfunction

    // Issue one start pulse and wait for done; checks latency, busy and outputs.
    task automatic run_div(input int av, input int bv, input int exp_q, input int exp_dz,
                           input string tag);
        int cyc;
        int busy_cyc;
        @(negedge clk);
        a = av[7:0];
        b = bv[7:0];
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 8'h5a;
        b = 8'h33;
        check({tag, "_busy_after_start"}, int'(busy), 1);
        cyc = 0;
        busy_cyc = 1;
        while (1) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) break;
            if (busy) busy_cyc++;
            if (cyc > 40) break;
        end
        check({tag, "_latency"}, cyc, (bv == 0) ? 1 : 16);
        check({tag, "_busy_cycles"}, busy_cyc, (bv == 0) ? 1 : 16);
        check({tag, "_busy_low_at_done"}, int'(busy), 0);
        check({tag, "_result"}, sres(), exp_q);
        check({tag, "_div_zero"}, int'(div_zero), exp_dz);
        @(posedge clk);
        #1;
        check({tag, "_done_one_cycle"}, int'(done), 0);
    endtask

    initial begin
        int done_at[$];
        int av, bv;
        int cyc;

        vecs.push_back('{32, 64, 64, 0});
        vecs.push_back('{-32, 64, -64, 0});
        vecs.push_back('{64, -128, -64, 0});
        vecs.push_back('{1, 3, 42, 0});
        vecs.push_back('{-1, 3, -42, 0});
        vecs.push_back('{64, 32, 127, 0});
        vecs.push_back('{-64, 32, -128, 0});
        vecs.push_back('{-128, -128, 127, 0});
        vecs.push_back('{5, 0, 127, 1});
        vecs.push_back('{-5, 0, -128, 1});
        vecs.push_back('{0, 0, 0, 1});
        vecs.push_back('{0, -7, 0, 0});
        vecs.push_back('{-64, 64, -128, 0});

        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_result", sres(), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_div_zero", int'(div_zero), 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i])
            run_div(vecs[i].a, vecs[i].b, vecs[i].exp_q, vecs[i].exp_dz, $sformatf("vec%0d", i));

        for (int i = 0; i < 150; i++) begin
            av = int'($signed(8'($urandom)));
            bv = int'($signed(8'($urandom)));
            if (i % 25 == 0) bv = 0;
            run_div(av, bv, ref_q(av, bv), (bv == 0) ? 1 : 0, $sformatf("rnd%0d", i));
        end

        // Start pulsed during RUN with other operands must be ignored.
        @(negedge clk);
        a = 8'd32; b = 8'd64; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        a = 8'd100; b = 8'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("ignore_done_seen", int'(done), 1);
        check("ignore_result", sres(), 64);
        check("ignore_no_restart", int'(busy), 0);
        repeat (3) @(posedge clk);
        #1;
        check("ignore_still_idle", int'(busy), 0);

        // Start held high: done every 17 cycles.
        @(negedge clk);
        a = 8'd1; b = 8'd3; start = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk);
            #1;
            if (done) done_at.push_back(c);
        end
        @(negedge clk);
        start = 1'b0;
        check("b2b_done_count", done_at.size(), 3);
        if (done_at.size() >= 3) begin
            check("b2b_period1", done_at[1] - done_at[0], 17);
            check("b2b_period2", done_at[2] - done_at[1], 17);
        end
        check("b2b_result", sres(), 42);
        repeat (20) @(posedge clk);

        // Reset in RUN cycle 5 abandons the division.
        @(negedge clk);
        a = 8'd100; b = 8'd7; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_result", sres(), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_div_zero", int'(div_zero), 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk);
            #1;
            if (done || busy) cyc++;
        end
        check("midrst_no_done", cyc, 0);
        run_div(32, 64, 64, 0, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
